reg_bus_master: RTL and testbench
=================================

Name: reg_bus_master

Overview:
- Upstream bus-master stage for the 8-bit register block: drives its addr/wdata/direction/enable bus and captures its registered rdata.
- Accepts read/write requests from the testbench/host side through a valid/ready port and buffers them in a small request FIFO.
- Serialises requests onto the register bus, one at a time, and returns exactly one response per request through a valid/ready port.
- Requests to addresses above MAX_ADDR are not issued on the bus; they complete with an error response.

Parameters:
- ADDR_W, 8, request and bus address width
- DATA_W, 8, request/bus/response data width
- DEPTH, 4, request FIFO entries (power of 2, >= 2)
- MAX_ADDR, 2, highest decoded register address; higher addresses error without a bus access

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  FIFO can accept; equals !full
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  register address
- req_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_write  out  1  echo of request type
- rsp_err  out  1  address > MAX_ADDR, no bus access made
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- bus_addr  out  ADDR_W  to register block addr
- bus_wdata  out  DATA_W  to register block wdata
- bus_direction  out  1  1=write, 0=read
- bus_enable  out  1  single-cycle access strobe
- bus_rdata  in  DATA_W  registered read data from register block

Behaviour:
- Reset (synchronous, active-high):
  - FIFO empty; FSM in IDLE.
  - All outputs registered and 0 after reset; req_ready=1 in the first cycle after rst deasserts.
  - rst asserted mid-transaction aborts it: FIFO contents and any pending response are discarded; bus_enable=0 the next cycle.
- Request FIFO:
  - Push on req_valid && req_ready.
  - Pop only by the FSM in IDLE.
  - Push and pop in the same cycle are allowed; the count is unchanged.
  - When full, req_ready=0 and there is no bypass.
  - Pointers wrap modulo DEPTH.
  - Count width is clog2(DEPTH)+1.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if the FIFO is non-empty, pop the head and latch it.
    - addr <= MAX_ADDR: load bus_addr/bus_wdata/bus_direction, set bus_enable, go to ISSUE.
    - addr > MAX_ADDR: set rsp_err=1 and rsp_rdata=0, go to RESP; bus_enable stays 0.
  - ISSUE: bus_enable=1 for exactly this one cycle.
    - Write: go to RESP; rsp_rdata=0.
    - Read: go to WAIT.
  - WAIT: bus_enable=0. The register block updated rdata at the ISSUE edge; capture bus_rdata into rsp_rdata at the end of this cycle, then go to RESP.
  - RESP: rsp_valid=1 with rsp_write/rsp_err/rsp_rdata held stable until rsp_ready is sampled high; then go to IDLE.
- Latency from the push edge, with an empty FIFO, idle FSM and rsp_ready=1:
  - Cycle +1: pop.
  - Cycle +2: bus_enable.
  - Write: rsp_valid at +3.
  - Read: rsp_valid at +4.
  - Error: rsp_valid at +2.
- Throughput: one bus access in flight at most.
  - bus_enable is never high on two consecutive cycles.
  - IDLE always takes at least one cycle between accesses.
- bus_addr, bus_wdata and bus_direction hold their last values when bus_enable=0.
- Responses are returned in request order.

Decomposition:
- Package reg_bus_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - request struct {write, addr, wdata}
  - ADDR_W/DATA_W defaults
- One sub-module, reg_bus_req_fifo: parameterised synchronous FIFO with count/full/empty.
- The FSM and response registers stay in reg_bus_master.

Test Plan:
- Write then read: write addr 1 data 0xA5, then read addr 1 -> bus_enable pulses at +2 of each; write response rsp_err=0, rsp_rdata=0x00; read response rsp_rdata=0xA5 at +4.
- Back-pressure: push 5 requests back-to-back with DEPTH=4 while rsp_ready=0 -> req_ready drops after the FIFO fills; no request is lost; responses arrive in order once rsp_ready=1.
- Unmapped address: read addr 0x07 -> no bus_enable pulse; response rsp_err=1, rsp_rdata=0x00 at +2.
- Response stall: hold rsp_ready=0 for 10 cycles during a read of addr 0 (written 0x3C) -> rsp_valid and rsp_rdata=0x3C stay stable; the next bus access only starts after acceptance.
- Reset mid-read: assert rst in the WAIT state with 2 entries queued -> next cycle rsp_valid=0, bus_enable=0, req_ready=1; no stale response appears afterwards.
- Simultaneous push/pop: FIFO holding 1 entry, push while FSM pops -> count stays 1; both requests are issued in order.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared types and defaults for the register-bus master.
//   state_t : master FSM states
//   req_t   : request record {write, addr, wdata} at the default widths;
//             the FIFO word in reg_bus_master uses the same field order
//             (write in the MSB, wdata in the LSBs) for any width.
package reg_bus_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/reg_bus_req_fifo.sv
// Synchronous request FIFO with occupancy count, full and empty flags.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : write request (ignored while full, no bypass)
//   pop               : remove head entry (ignored while empty)
//   head              : current head entry (combinational read)
//   full, empty       : occupancy flags derived from the count register
module reg_bus_req_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  // Head is read combinationally so the master can pop and latch the
  // request on the same edge.
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/reg_bus_master.sv
// Bus-master front end for the 8-bit register block.
// Requests enter through a valid/ready port into a small FIFO, are issued
// one at a time as single-cycle bus_enable strobes, and each produces one
// response on a valid/ready port, in request order. Addresses above
// MAX_ADDR are answered with rsp_err=1 without touching the bus.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid/req_ready              : request handshake (req_ready = !full)
//   req_write, req_addr, req_wdata   : request payload
//   rsp_valid/rsp_ready              : response handshake
//   rsp_write, rsp_err, rsp_rdata    : response payload
//   bus_addr, bus_wdata,
//   bus_direction, bus_enable        : register-block bus (all registered)
//   bus_rdata                        : registered read data from the block
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_direction,
  output logic              bus_enable,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int REQ_W = 1 + ADDR_W + DATA_W;

  logic [REQ_W-1:0]  fifo_head;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              bus_dir_q, bus_dir_d;
  logic              bus_enable_q, bus_enable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  reg_bus_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid),
    .push_data ({req_write, req_addr, req_wdata}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_write = fifo_head[REQ_W-1];
  assign head_addr  = fifo_head[ADDR_W+DATA_W-1:DATA_W];
  assign head_wdata = fifo_head[DATA_W-1:0];

  always_comb begin
    state_d      = state_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_dir_d    = bus_dir_q;
    bus_enable_d = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_write_d  = rsp_write_q;
    rsp_err_d    = rsp_err_q;
    rsp_rdata_d  = rsp_rdata_q;
    fifo_pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          rsp_write_d = head_write;
          rsp_rdata_d = '0;
          if (head_addr <= MAX_ADDR) begin
            bus_addr_d   = head_addr;
            bus_wdata_d  = head_wdata;
            bus_dir_d    = head_write;
            bus_enable_d = 1'b1;
            rsp_err_d    = 1'b0;
            state_d      = ISSUE;
          end else begin
            // Unmapped: answer directly, the bus is left untouched.
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      ISSUE: begin
        if (bus_dir_q) begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The block registered its read data on the ISSUE edge.
        rsp_rdata_d = bus_rdata;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_dir_q    <= 1'b0;
      bus_enable_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_dir_q    <= bus_dir_d;
      bus_enable_q <= bus_enable_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_write_q  <= rsp_write_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign req_ready     = !fifo_full;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_direction = bus_dir_q;
  assign bus_enable    = bus_enable_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: a behavioural 3-register block answers the bus,
// a scoreboard queue holds expected responses in request order, a table of
// single requests checks payload and latency, and hand-written sequences
// cover back-pressure, response stall, reset abort and push/pop overlap.
module tb_reg_bus_master;
  import reg_bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [7:0] rsp_rdata;
  logic [7:0] bus_addr, bus_wdata, bus_rdata;
  logic       bus_direction, bus_enable;

  always #5 clk = ~clk;

  reg_bus_master #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .DEPTH    (4),
    .MAX_ADDR (8'd2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_err       (rsp_err),
    .rsp_rdata     (rsp_rdata),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_direction (bus_direction),
    .bus_enable    (bus_enable),
    .bus_rdata     (bus_rdata)
  );

  // Register block model: registered read, write on the enable edge.
  logic [7:0] regs [0:2] = '{default: 8'h00};
  logic [7:0] rb_rdata = 8'h00;
  assign bus_rdata = rb_rdata;

  always @(posedge clk) begin
    if (bus_enable === 1'b1 && bus_addr <= 8'd2) begin
      if (bus_direction) regs[bus_addr[1:0]] <= bus_wdata;
      else               rb_rdata <= regs[bus_addr[1:0]];
    end
  end

  typedef struct packed {
    logic       w;
    logic       err;
    logic [7:0] rd;
  } exp_t;

  typedef struct {
    req_t       req;
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         exp_en;
    int         exp_rsp;
  } vec_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  vec_t       vecs[10];
  logic [7:0] shadow [0:2];
  int         total = 0;
  int         bad = 0;
  int         en_count = 0;
  logic       prev_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Bus and response monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus_enable === 1'b1) begin
        en_count++;
        check("bus_gap_addr", {31'd0, prev_en, (bus_addr <= 8'd2)}, 32'd1);
      end
      prev_en = bus_enable;
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got w=%0b err=%0b rdata=0x%0h exp=none",
                   rsp_write, rsp_err, rsp_rdata);
        end else begin
          mon_e = sb_q.pop_front();
          check("rsp_payload", {22'd0, rsp_write, rsp_err, rsp_rdata}, {22'd0, mon_e});
          $display("rsp w=%0b err=%0b rdata=0x%02h", rsp_write, rsp_err, rsp_rdata);
        end
      end
    end else begin
      prev_en = 1'b0;
    end
  end

  // Called at posedge+2; returns at push edge +2 with req_valid low.
  task automatic push_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input bit sb, input exp_t e);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got req_ready=%0b exp=1", req_ready);
    end else if (sb) begin
      sb_q.push_back(e);
    end
    @(posedge clk);
    #2;
    req_valid = 1'b0;
  endtask

  task automatic exp_push(input logic w, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.w   = w;
    e.err = (a > 8'd2);
    e.rd  = (w || e.err) ? 8'h00 : shadow[a[1:0]];
    if (w && !e.err) shadow[a[1:0]] = d;
    push_req(w, a, d, 1'b1, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got pending=%0d exp=0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #2;
  endtask

  task automatic set_vec(input int i, input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic err, input logic [7:0] rd, input int en, input int rl);
    vecs[i].req.write = w;
    vecs[i].req.addr  = a;
    vecs[i].req.wdata = d;
    vecs[i].exp_err   = err;
    vecs[i].exp_rdata = rd;
    vecs[i].exp_en    = en;
    vecs[i].exp_rsp   = rl;
  endtask

  // One isolated request; latency k = k-th falling edge after the push edge.
  task automatic run_vec(input int i);
    int   en_lat, rsp_lat;
    exp_t e;
    en_lat  = 0;
    rsp_lat = 0;
    e = {vecs[i].req.write, vecs[i].exp_err, vecs[i].exp_rdata};
    if (vecs[i].req.write && vecs[i].req.addr <= 8'd2)
      shadow[vecs[i].req.addr[1:0]] = vecs[i].req.wdata;
    push_req(vecs[i].req.write, vecs[i].req.addr, vecs[i].req.wdata, 1'b1, e);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus_enable === 1'b1 && en_lat == 0) en_lat = k;
      if (rsp_valid === 1'b1 && rsp_lat == 0) rsp_lat = k;
    end
    check($sformatf("lat_en_v%0d", i), en_lat, vecs[i].exp_en);
    check($sformatf("lat_rsp_v%0d", i), rsp_lat, vecs[i].exp_rsp);
    $display("vec %0d w=%0b addr=0x%02h en_lat=%0d rsp_lat=%0d",
             i, vecs[i].req.write, vecs[i].req.addr, en_lat, rsp_lat);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, en0, stale;
    logic ok;
    shadow[0] = 8'h00; shadow[1] = 8'h00; shadow[2] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00; rsp_ready = 1'b1;

    set_vec(0, 1'b1, 8'h01, 8'hA5, 1'b0, 8'h00, 2, 3);
    set_vec(1, 1'b0, 8'h01, 8'h00, 1'b0, 8'hA5, 2, 4);
    set_vec(2, 1'b0, 8'h07, 8'h00, 1'b1, 8'h00, 0, 2);
    set_vec(3, 1'b1, 8'h00, 8'h3C, 1'b0, 8'h00, 2, 3);
    set_vec(4, 1'b0, 8'h00, 8'h00, 1'b0, 8'h3C, 2, 4);
    set_vec(5, 1'b1, 8'h02, 8'h5A, 1'b0, 8'h00, 2, 3);
    set_vec(6, 1'b0, 8'h02, 8'h00, 1'b0, 8'h5A, 2, 4);
    set_vec(7, 1'b0, 8'h03, 8'h00, 1'b1, 8'h00, 0, 2);
    set_vec(8, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00, 0, 2);
    set_vec(9, 1'b0, 8'h02, 8'h00, 1'b0, 8'h5A, 2, 4);

    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {rsp_valid, rsp_write, rsp_err, rsp_rdata, bus_addr, bus_wdata, bus_direction, bus_enable},
          32'd0);
    check("reset_req_ready", req_ready, 1);
    @(posedge clk);
    #2;

    for (int i = 0; i < 10; i++) run_vec(i);
    drain();

    // Back-pressure: five pushes into a 4-deep FIFO with responses stalled.
    rsp_ready = 1'b0;
    exp_push(1'b1, 8'h00, 8'h11);
    exp_push(1'b1, 8'h01, 8'h22);
    exp_push(1'b1, 8'h02, 8'h33);
    exp_push(1'b0, 8'h00, 8'h00);
    exp_push(1'b0, 8'h01, 8'h00);
    @(negedge clk);
    check("bp_full_ready", req_ready, 0);
    check("bp_head_held", {rsp_valid, rsp_write, rsp_err}, 3'b110);
    repeat (3) @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    drain();

    // Response stall on a read of addr 0 holding 0x3C.
    exp_push(1'b1, 8'h00, 8'h3C);
    drain();
    rsp_ready = 1'b0;
    exp_push(1'b0, 8'h00, 8'h00);
    exp_push(1'b1, 8'h01, 8'h77);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_rsp_seen", rsp_valid, 1);
    en0 = en_count;
    ok  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(rsp_valid === 1'b1 && rsp_rdata === 8'h3C)) ok = 1'b0;
    end
    check("stall_rsp_stable", ok, 1);
    check("stall_no_bus", en_count - en0, 0);
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    drain();
    check("stall_next_access", en_count - en0, 1);

    // Reset while a read sits in WAIT with two entries queued.
    push_req(1'b0, 8'h01, 8'h00, 1'b0, '0);
    push_req(1'b1, 8'h02, 8'h99, 1'b0, '0);
    push_req(1'b0, 8'h00, 8'h00, 1'b0, '0);
    check("rst_pre_wait", {bus_enable, rsp_valid, bus_direction, bus_addr}, {3'b000, 8'h01});
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_abort", {rsp_valid, bus_enable, req_ready}, 3'b001);
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) stale++;
    end
    check("rst_no_stale", stale, 0);
    @(posedge clk);
    #2;
    exp_push(1'b0, 8'h01, 8'h00);
    exp_push(1'b0, 8'h02, 8'h00);
    drain();

    // Push and pop on the same edge with one entry queued.
    rsp_ready = 1'b0;
    exp_push(1'b1, 8'h00, 8'h44);
    exp_push(1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    en0 = en_count;
    check("pp_count_before", dut.u_fifo.count_q, 1);
    exp_push(1'b0, 8'h02, 8'h00);
    check("pp_count_after", dut.u_fifo.count_q, 1);
    drain();
    check("pp_both_issued", en_count - en0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
